// File: rtl/alu_seq.sv
// Clocked ALU: single-cycle ops plus an optional multi-cycle shift-add multiply.
// Define ALU_MUL_EN to build the MUL state; otherwise opcode 1001 is a NOP.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] ra,
   input  logic [WIDTH-1:0] rb,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out,
   output logic [2:0]       flags,
   output logic [WIDTH-1:0] out_port,
   output logic             out_port_strb,
   output logic             busy,
   output logic             done
);

   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_NAND = 4'b0011;
   localparam logic [3:0] OP_SHL  = 4'b0100;
   localparam logic [3:0] OP_SHR  = 4'b0101;
   localparam logic [3:0] OP_OUT  = 4'b0110;
   localparam logic [3:0] OP_IN   = 4'b0111;
   localparam logic [3:0] OP_MOV  = 4'b1000;

   logic [WIDTH:0]   add_s, sub_s;
   logic [WIDTH-1:0] res;
   logic             c_new, c_upd, single_go;

   assign add_s = {1'b0, ra} + {1'b0, rb};
   assign sub_s = {1'b0, ra} - {1'b0, rb};

   always_comb begin
      res   = ra;
      c_new = 1'b0;
      c_upd = 1'b0;
      case (op)
         OP_ADD:  begin res = add_s[WIDTH-1:0]; c_new = add_s[WIDTH]; c_upd = 1'b1; end
         OP_SUB:  begin res = sub_s[WIDTH-1:0]; c_new = sub_s[WIDTH]; c_upd = 1'b1; end
         OP_NAND: res = ~(ra & rb);
         OP_SHL:  begin res = {ra[WIDTH-2:0], 1'b0}; c_new = ra[WIDTH-1]; c_upd = 1'b1; end
         OP_SHR:  begin res = {1'b0, ra[WIDTH-1:1]}; c_new = ra[0]; c_upd = 1'b1; end
         OP_OUT:  res = ra;
         OP_IN:   res = in_port;
         OP_MOV:  res = rb;
         default: res = ra;
      endcase
   end

`ifdef ALU_MUL_EN
   localparam logic [3:0] OP_MUL = 4'b1001;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, MUL} state_t;
   state_t             state;
   logic [WIDTH-1:0]   mul_a;
   logic [2*WIDTH-1:0] acc, acc_nxt;
   logic [CW-1:0]      cnt;
   logic [WIDTH:0]     hi_sum;

   // acc = {partial high, remaining multiplier bits}; add into the top, shift right
   assign hi_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mul_a} : '0);
   assign acc_nxt   = {hi_sum, acc[WIDTH-1:1]};
   assign single_go = start && (state == IDLE) && (op != OP_MUL);
`else
   assign single_go = start;
   assign busy      = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out           <= '0;
         flags         <= '0;
         out_port      <= '0;
         out_port_strb <= 1'b0;
         done          <= 1'b0;
`ifdef ALU_MUL_EN
         busy          <= 1'b0;
         state         <= IDLE;
         mul_a         <= '0;
         acc           <= '0;
         cnt           <= '0;
`endif
      end else begin
         done          <= 1'b0;
         out_port_strb <= 1'b0;
         if (single_go) begin
            out   <= res;
            flags <= {res == '0, res[WIDTH-1], c_upd ? c_new : flags[0]};
            done  <= 1'b1;
            if (op == OP_OUT) begin
               out_port      <= ra;
               out_port_strb <= 1'b1;
            end
         end
`ifdef ALU_MUL_EN
         case (state)
            IDLE: if (start && op == OP_MUL) begin
               mul_a <= ra;
               acc   <= {{WIDTH{1'b0}}, rb};
               cnt   <= CW'(WIDTH);
               busy  <= 1'b1;
               state <= MUL;
            end
            MUL: begin
               acc <= acc_nxt;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  out   <= acc_nxt[WIDTH-1:0];
                  flags <= {acc_nxt[WIDTH-1:0] == '0, acc_nxt[WIDTH-1],
                            acc_nxt[2*WIDTH-1:WIDTH] != '0};
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
`endif
      end
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Clocked, parametrised successor to the lab CPU's combinational ALU. It executes one operation per `start` request and registers the result and the Z/N/C flags. A registered output port with a strobe carries OUT data. Multiply is a multi-cycle shift-add operation behind a start/busy/done handshake. The block sits between the register file read ports and the write-back mux, and the control FSM stalls on `busy`.

## Interface
- `WIDTH`, default 8: datapath width of `ra`, `rb`, `in_port`, `out`, `out_port`; legal values 4 to 32.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `op`  in  4  opcode, sampled with `start`.
- `ra`  in  WIDTH  operand A, sampled with `start`.
- `rb`  in  WIDTH  operand B, sampled with `start`.
- `in_port`  in  WIDTH  external input, sampled with `start`.
- `out`  out  WIDTH  registered result; holds until the next completion.
- `flags`  out  3  registered {Z,N,C}.
- `out_port`  out  WIDTH  registered output port; holds until the next OUT.
- `out_port_strb`  out  1  one-cycle pulse when `out_port` is updated.
- `busy`  out  1  a multiply is in progress.
- `done`  out  1  one-cycle pulse; `out` and `flags` are valid from this cycle.

## Operation
- Opcodes:
  - 0001 ADD: `ra`+`rb`
  - 0010 SUB: `ra`-`rb`
  - 0011 NAND
  - 0100 SHL by 1
  - 0101 SHR by 1 (logical)
  - 0110 OUT
  - 0111 IN: result = `in_port`
  - 1000 MOV: result = `rb`
  - 1001 MUL
  - all others NOP: result = `ra`
- States: IDLE, MUL.
- IDLE, `start`=1 with a non-MUL op: result is computed and registered at that edge. `done`=1 for the following cycle. The state stays IDLE.
- IDLE, `start`=1 with MUL: operands are latched, an iteration counter is loaded with WIDTH, and the state goes to MUL.
- MUL: one shift-add step per cycle on a 2·WIDTH accumulator. When the counter reaches 0 the block registers the low WIDTH bits to `out`, pulses `done` and returns to IDLE.
- Flag rules, applied on every completion:
  - Z = (result == 0); N = result[WIDTH-1].
  - C by op:
    - ADD: carry-out
    - SUB: borrow (`ra` < `rb`, unsigned)
    - SHL: `ra`[WIDTH-1]
    - SHR: `ra`[0]
    - MUL: high half of product nonzero
    - all other ops: C unchanged
- OUT:
  - `out_port` <= `ra` and `out_port_strb` pulses in the same cycle as `done`.
  - `out` <= `ra`; Z and N update, C is unchanged.
  - `out_port` changes on no other op.
- `start` while `busy`=1 is ignored: no queueing and no effect on the operation in flight.
- Back-to-back: `start` during a `done` cycle is accepted, since `busy`=0 in that cycle.
- Reset (asynchronous, any state, including mid-MUL):
  - `out`, `flags`, `out_port`, `out_port_strb`, `busy`, `done`, the accumulator and the counter go to 0.
  - The state goes to IDLE; an in-flight multiply is discarded with no `done`.

## Timing
- `start` sampled at edge k with a non-MUL op: `done`, `out` and `flags` are valid in cycle k+1. Latency is 1.
- MUL sampled at edge k:
  - `busy`=1 in cycles k+1 through k+WIDTH.
  - `done`=1 in cycle k+WIDTH+1, with `busy`=0.
- `busy` and `done` are never both high.
- Sustained throughput is one non-MUL op per cycle, or one MUL per WIDTH+1 cycles.

## Configuration
- `ALU_MUL_EN` defined: the MUL state, counter and accumulator are compiled in and opcode 1001 behaves as described above.
- `ALU_MUL_EN` undefined:
  - Opcode 1001 decodes as NOP: result = `ra`, single-cycle, C unchanged.
  - `busy` is tied to 0 and the MUL state does not exist.

## Test plan
All scenarios use WIDTH=8.
- ADD `ra`=0xF0, `rb`=0x20 -> next cycle `out`=0x10, Z=0, N=0, C=1, `done` high for 1 cycle.
- SUB 0x05-0x05 -> `out`=0x00, Z=1, C=0. Then SUB 0x03-0x05 -> `out`=0xFE, N=1, C=1. Then NAND 0xFF,0xFF -> 0x00, Z=1, C stays 1.
- MUL 0x0D×0x0B -> `busy` for 8 cycles, `out`=0x8F, C=0, N=1, `done` at k+9. MUL 0x20×0x10 -> `out`=0x00, Z=1, C=1.
- OUT with `ra`=0x5A -> `out_port`=0x5A with `out_port_strb` for 1 cycle. A following ADD leaves `out_port` at 0x5A.
- `start` with ADD asserted at k+3 of a MUL -> ignored; the MUL result is unaffected. `rst_n` low at k+4 -> all outputs 0 immediately, no `done`. After release, ADD 1+1 -> `out`=0x02.
- Without `ALU_MUL_EN`: opcode 1001 with `ra`=0x33 -> `out`=0x33 after 1 cycle, `busy` never asserted.
